// File: rtl/svc_axi_tgen.sv
// AXI4 manager traffic generator: writes one INCR burst of seed+beat, waits for B,
// reads the range back and checks every beat; reports done with a pass/fail result.
module svc_axi_tgen #(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [AXI_DATA_WIDTH-1:0] seed,
    input  logic [7:0]                len,
    input  logic [AXI_ID_WIDTH-1:0]   id,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      m_axi_awvalid,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    input  logic                      m_axi_awready,
    output logic                      m_axi_wvalid,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    input  logic                      m_axi_wready,
    input  logic                      m_axi_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    output logic                      m_axi_bready,
    output logic                      m_axi_arvalid,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic                      m_axi_arready,
    input  logic                      m_axi_rvalid,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    output logic                      m_axi_rready,
    output logic [2:0]                o_dbg_state
);
    // Every channel transfers exactly on a rising edge where valid && ready are both high.
    localparam logic [2:0]                AXSIZE   = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [AXI_DATA_WIDTH-1:0] DATA_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD, S_CHK} state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_seed, r_wdata, r_rexp;
    logic [7:0]                r_len, r_beat;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic r_err, r_busy, r_done, r_pass;
    logic r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
    logic r_aw_done, r_w_done, r_ar_done, r_rl_done;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_aw_fin, w_w_fin, w_ar_fin, w_rl_fin, w_b_bad, w_r_bad;

    assign w_aw_hs  = r_awvalid & m_axi_awready;
    assign w_w_hs   = r_wvalid & m_axi_wready;
    assign w_b_hs   = r_bready & m_axi_bvalid;
    assign w_ar_hs  = r_arvalid & m_axi_arready;
    assign w_r_hs   = r_rready & m_axi_rvalid;
    // "fin" folds in the handshake of this very edge so exits take no extra cycle.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | (w_w_hs & r_wlast);
    assign w_ar_fin = r_ar_done | w_ar_hs;
    assign w_rl_fin = r_rl_done | (w_r_hs & m_axi_rlast);
    assign w_b_bad  = (m_axi_bresp != 2'b00) || (m_axi_bid != r_id);
    assign w_r_bad  = w_r_hs && ((m_axi_rdata != r_rexp) || (m_axi_rid != r_id) ||
                                 (m_axi_rresp != 2'b00) || (m_axi_rlast != (r_beat == r_len)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_seed    <= '0;
            r_wdata   <= '0;
            r_rexp    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_id      <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
            r_rl_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_addr    <= base_addr;
                        r_seed    <= seed;
                        r_len     <= len;
                        r_id      <= id;
                        r_err     <= 1'b0;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= seed;
                        r_wlast   <= (len == 8'd0);
                        r_beat    <= 8'd0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_wdata <= r_wdata + DATA_ONE;
                            r_wlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_b_hs) begin
                        if (w_b_bad) r_err <= 1'b1;
                        r_bready  <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_beat    <= 8'd0;
                        r_rexp    <= r_seed;
                        r_ar_done <= 1'b0;
                        r_rl_done <= 1'b0;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_ar_done <= 1'b1;
                    end
                    if (w_r_hs) begin
                        if (w_r_bad) r_err <= 1'b1;
                        r_beat <= r_beat + 8'd1;
                        r_rexp <= r_rexp + DATA_ONE;
                        if (m_axi_rlast) begin
                            r_rready  <= 1'b0;
                            r_rl_done <= 1'b1;
                        end
                    end
                    if (w_ar_fin && w_rl_fin) begin
                        r_rready <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= ~(r_err | w_r_bad);
                        r_busy   <= 1'b0;
                        r_state  <= S_CHK;
                    end
                end
                S_CHK: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awid    = r_id;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wlast;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_arid    = r_id;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = r_rready;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_svc_axi_tgen.sv
// Directed bench for svc_axi_tgen: an AXI memory responder with optional stalls and
// fault injection; W data and run results are scoreboarded through expectation queues.
module tb_svc_axi_tgen;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int IDW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] seed = '0;
    logic [7:0]    len = '0;
    logic [IDW-1:0] id = '0;
    logic busy, done, pass;
    logic m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [IDW-1:0] m_axi_awid, m_axi_arid;
    logic [AW-1:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]     m_axi_awlen, m_axi_arlen;
    logic [2:0]     m_axi_awsize, m_axi_arsize, dbg_state;
    logic [1:0]     m_axi_awburst, m_axi_arburst;
    logic [DW-1:0]  m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [IDW-1:0] m_axi_bid = '0, m_axi_rid = '0;
    logic [1:0]     m_axi_bresp = '0, m_axi_rresp = '0;
    logic [DW-1:0]  m_axi_rdata = '0;

    svc_axi_tgen #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .seed(seed),
        .len(len), .id(id), .busy(busy), .done(done), .pass(pass),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [0:0]    pass_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- responder ----------------
    bit stall = 0, inj_bresp = 0, corrupt_r = 0, omit_rlast = 0;
    logic [AW-1:0]  exp_base = '0;
    logic [7:0]     exp_len = '0;
    logic [IDW-1:0] exp_id = '0;
    int done_cnt = 0;

    bit c_aw, c_w, c_b, c_ar, c_r;
    logic [AW-1:0] c_awaddr, c_araddr;
    logic [7:0] c_awlen, c_arlen;
    logic [IDW-1:0] c_awid, c_arid;
    logic [2:0] c_awsize, c_arsize;
    logic [1:0] c_awburst, c_arburst;
    logic [DW-1:0] c_wdata;
    logic [DW/8-1:0] c_wstrb;
    logic c_wlast;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] wbuf [0:511];
    bit aw_got = 0, w_got = 0, ar_got = 0;
    int wcnt = 0, rcnt = 0, r_total = 0;
    logic [AW-1:0] aw_base = '0, ar_base = '0;
    logic [IDW-1:0] aw_id = '0, ar_id = '0;

    function automatic bit rnd();
        return !stall || ($urandom_range(0, 1) == 1);
    endfunction

    // Handshakes are captured on the active edge, then acted on at the falling edge.
    always @(posedge clk) begin
        c_aw = m_axi_awvalid && m_axi_awready;
        c_awaddr = m_axi_awaddr; c_awlen = m_axi_awlen; c_awid = m_axi_awid;
        c_awsize = m_axi_awsize; c_awburst = m_axi_awburst;
        c_w = m_axi_wvalid && m_axi_wready;
        c_wdata = m_axi_wdata; c_wstrb = m_axi_wstrb; c_wlast = m_axi_wlast;
        c_b = m_axi_bvalid && m_axi_bready;
        c_ar = m_axi_arvalid && m_axi_arready;
        c_araddr = m_axi_araddr; c_arlen = m_axi_arlen; c_arid = m_axi_arid;
        c_arsize = m_axi_arsize; c_arburst = m_axi_arburst;
        c_r = m_axi_rvalid && m_axi_rready;
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_got = 0; w_got = 0; ar_got = 0; wcnt = 0; rcnt = 0; r_total = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        end else begin
            if (c_aw) begin
                check("awaddr", c_awaddr, exp_base);
                check("awlen", c_awlen, exp_len);
                check("awid", c_awid, exp_id);
                check("awsize", c_awsize, 3'd1);
                check("awburst", c_awburst, 2'b01);
                aw_got = 1; aw_base = c_awaddr; aw_id = c_awid;
            end
            m_axi_awready = !aw_got && rnd();
            if (c_w) begin
                if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
                else check("wdata", c_wdata, exp_q.pop_front());
                check("wstrb", c_wstrb, 2'b11);
                check("wlast", c_wlast, (wcnt == int'(exp_len)));
                wbuf[wcnt] = c_wdata;
                wcnt++;
                if (c_wlast) w_got = 1;
            end
            m_axi_wready = !w_got && rnd();
            if (c_b) begin
                m_axi_bvalid = 0; aw_got = 0; w_got = 0; wcnt = 0;
            end else if (aw_got && w_got && !m_axi_bvalid) begin
                for (int i = 0; i < wcnt; i++) mem[int'(aw_base >> 1) + i] = wbuf[i];
                m_axi_bvalid = 1; m_axi_bid = aw_id;
                m_axi_bresp = inj_bresp ? 2'b10 : 2'b00;
            end
            if (c_ar) begin
                check("araddr", c_araddr, exp_base);
                check("arlen", c_arlen, exp_len);
                check("arid", c_arid, exp_id);
                check("arsize", c_arsize, 3'd1);
                check("arburst", c_arburst, 2'b01);
                ar_got = 1; ar_base = c_araddr; ar_id = c_arid;
                rcnt = 0; r_total = int'(c_arlen) + 1 + (omit_rlast ? 1 : 0);
            end
            m_axi_arready = !ar_got && rnd();
            if (c_r) begin
                rcnt++;
                m_axi_rvalid = 0;
                if (rcnt == r_total) ar_got = 0;
            end
            if (ar_got && !m_axi_rvalid && rcnt < r_total && rnd()) begin
                m_axi_rvalid = 1;
                m_axi_rdata = mem[int'(ar_base >> 1) + rcnt] ^ ((corrupt_r && rcnt == 2) ? 16'h0100 : 16'h0000);
                m_axi_rlast = (rcnt == r_total - 1);
                m_axi_rid = ar_id; m_axi_rresp = 2'b00;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic push_data(input logic [DW-1:0] s, input logic [7:0] l);
        logic [DW-1:0] v;
        v = s;
        for (int k = 0; k <= int'(l); k++) begin
            exp_q.push_back(v);
            v = v + 16'd1;
        end
    endtask

    task automatic run_test(input logic [AW-1:0] b, input logic [DW-1:0] s, input logic [7:0] l,
                            input logic [IDW-1:0] i, input logic ep, input bit poke);
        int d0;
        bit got;
        exp_base = b; exp_len = l; exp_id = i;
        push_data(s, l);
        pass_q.push_back(ep);
        @(negedge clk);
        base_addr = b; seed = s; len = l; id = i; start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy, 1);
        d0 = done_cnt;
        if (poke) begin
            repeat (2) @(negedge clk);
            seed = ~s; len = l + 8'd1; start = 1;
            @(negedge clk);
            start = 0;
        end
        got = 0;
        for (int n = 0; n < 4000; n++) begin
            if (done) begin got = 1; break; end
            @(negedge clk);
        end
        check("done_seen", got, 1);
        if (got) begin
            check("pass", pass, pass_q.pop_front());
            check("busy_at_done", busy, 0);
            if (poke) begin
                start = 1;
                @(negedge clk);
                start = 0;
            end else @(negedge clk);
            repeat (3) @(negedge clk);
            check("done_once", done_cnt - d0, 1);
            check("pass_held", pass, ep);
            check("busy_idle", busy, 0);
        end else begin
            pass_q.delete();
        end
        check("wdata_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        for (int k = 0; k < 1024; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        run_test(8'hA0, 16'hD000, 8'd3, 4'hD, 1'b1, 0);
        run_test(8'h10, 16'hFFFE, 8'd3, 4'h3, 1'b1, 0);
        run_test(8'h40, 16'h1234, 8'd0, 4'h1, 1'b1, 0);
        stall = 1;
        run_test(8'h20, 16'h0100, 8'd7, 4'h7, 1'b1, 1);
        stall = 0; inj_bresp = 1;
        run_test(8'hA0, 16'hD000, 8'd3, 4'hD, 1'b0, 0);
        inj_bresp = 0;
        run_test(8'hA0, 16'hD000, 8'd3, 4'hD, 1'b1, 0);
        corrupt_r = 1;
        run_test(8'h30, 16'h5555, 8'd3, 4'h2, 1'b0, 0);
        corrupt_r = 0; omit_rlast = 1;
        run_test(8'h30, 16'hAAAA, 8'd3, 4'h4, 1'b0, 0);
        omit_rlast = 0; stall = 1;
        run_test(8'h00, 16'h0042, 8'd255, 4'hF, 1'b1, 0);

        // Abort a burst with reset while the write phase is in flight.
        exp_base = 8'h60; exp_len = 8'd7; exp_id = 4'h6;
        push_data(16'h7000, 8'd7);
        @(negedge clk);
        base_addr = 8'h60; seed = 16'h7000; len = 8'd7; id = 4'h6; start = 1;
        @(negedge clk);
        start = 0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        check("wr_state_before_reset", dbg_state, 1);
        #2 rst_n = 0;
        #1;
        check("arst_awvalid", m_axi_awvalid, 0);
        check("arst_wvalid", m_axi_wvalid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_state", dbg_state, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("arst_no_done", done_cnt - d0, 0);
        stall = 0;
        run_test(8'hA0, 16'hD000, 8'd3, 4'hD, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
